conv_window_addr_gen: RTL
=========================

Name: conv_window_addr_gen

Overview:
- Parametrised successor to the single-dot-product address stepper.
- Walks a complete convolution pass over a multi-channel image. For every output position it emits one image address and one weight address per filter tap, across all channels.
- Filter size, image size, stride and channel count are set at runtime and latched at start.
- Output stream uses valid/ready backpressure. Per-dot-product and per-frame markers feed the XNOR/popcount datapath and the image/weight BRAM readers.

Parameters:
- ADDR_W, 16, width of img_addr and wgt_addr.
- DIM_W, 8, width of row/column/filter/stride config and position counters.
- CH_W, 4, width of channel count and channel counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  one-cycle request; accepted only in IDLE
- cfg_img_rows  in  DIM_W  image rows
- cfg_img_cols  in  DIM_W  image columns
- cfg_flt_rows  in  DIM_W  filter rows
- cfg_flt_cols  in  DIM_W  filter columns
- cfg_stride  in  DIM_W  window stride, same for rows and columns
- cfg_channels  in  CH_W  number of input channels
- addr_valid  out  1  img_addr/wgt_addr hold a valid tap
- addr_ready  in  1  consumer accepts the tap this cycle
- img_addr  out  ADDR_W  image memory address
- wgt_addr  out  ADDR_W  weight memory address
- dp_last  out  1  qualifies the final tap of one dot product (last ch, fr, fc)
- out_row  out  DIM_W  output row index of the current window
- out_col  out  DIM_W  output column index of the current window
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse after the final tap handshake
- cfg_err  out  1  one-cycle pulse when start is rejected for bad config

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs and counters go to 0.
  - Reset mid-pass abandons the pass; no done is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1, config is latched into internal registers; later cfg_* changes are ignored until the next IDLE.
  - The config is invalid if any dimension, stride or channel count is 0, or if flt_rows>img_rows, or if flt_cols>img_cols.
  - Invalid config: cfg_err=1 for one cycle and the block stays in IDLE.
  - Valid config: all counters clear and the state goes to RUN on the next edge. addr_valid=1 in the first RUN cycle, i.e. one-cycle latency from start.
- Counters: fc (innermost), fr, ch, window column origin c0, window row origin r0 (outermost).
- Advance happens only when addr_valid&&addr_ready:
  - fc increments; at flt_cols-1 it wraps to 0 and carries into fr.
  - fr wraps at flt_rows-1 and carries into ch.
  - ch wraps at channels-1 and carries into c0.
  - c0 advances by stride if c0+stride+flt_cols<=img_cols; otherwise it wraps to 0 and carries into r0.
  - r0 advances by stride under the same rule against img_rows; if r0 cannot advance, the pass ends.
  - out_col/out_row increment or reset alongside c0/r0; no divider is used.
- Addresses are registered and truncated mod 2^ADDR_W:
  - img_addr = ch*img_rows*img_cols + (r0+fr)*img_cols + (c0+fc)
  - wgt_addr = (ch*flt_rows + fr)*flt_cols + fc
- Backpressure: while addr_valid=1 and addr_ready=0, every output holds stable. No tap is dropped or duplicated.
- Final handshake:
  - The handshake on the last tap (dp_last=1 on the last window) moves the state to DONE.
  - addr_valid=0 from the next cycle.
  - done=1 for exactly one cycle in DONE, then the state returns to IDLE.
- start while busy is ignored and does not set cfg_err.
- Throughput: one tap per cycle with addr_ready held high; no bubbles between windows or channels.
- Degenerate window: filter equal to the image gives exactly one window (out_row=out_col=0).

Test Plan:
- Image 4x4, filter 2x2, stride 1, 1 channel, ready=1 -> 36 taps, 9 windows.
  - First window img_addr 0,1,4,5 with dp_last on 5.
  - Last window img_addr 10,11,14,15, out_row=2, out_col=2.
  - done one cycle after the final handshake.
- Same config with stride 2 -> 4 windows with origins at img_addr 0,2,8,10; 16 taps; out_row/out_col in {0,1}.
- Image 3x3, filter 2x2, stride 1, 2 channels -> 32 taps.
  - Window 0 img_addr 0,1,3,4,9,10,12,13.
  - wgt_addr 0..7 per window; dp_last every 8th tap.
- Pseudo-random addr_ready on the first scenario -> identical 36-tap sequence versus the ready=1 golden run; outputs stable while stalled.
- Config errors: filter 5x2 on a 4x4 image -> cfg_err one-cycle pulse, addr_valid stays 0, busy=0. Repeat with stride=0 and channels=0: same response.
- reset=0 asserted asynchronously at tap 10 of the first scenario -> all outputs 0 immediately, no done. A fresh start then reproduces the full 36 taps from img_addr 0.

Source files
------------

// File: rtl/conv_window_addr_gen_if.sv
// Tap stream from the convolution address generator to the BRAM readers / XNOR datapath.
// The master drives addresses and window markers; the slave returns addr_ready.
interface conv_window_addr_gen_if #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
);
    logic              addr_valid;
    logic              addr_ready;
    logic [ADDR_W-1:0] img_addr;
    logic [ADDR_W-1:0] wgt_addr;
    logic              dp_last;
    logic [DIM_W-1:0]  out_row;
    logic [DIM_W-1:0]  out_col;

    modport master (
        output addr_valid, img_addr, wgt_addr, dp_last, out_row, out_col,
        input  addr_ready
    );

    modport slave (
        input  addr_valid, img_addr, wgt_addr, dp_last, out_row, out_col,
        output addr_ready
    );
endinterface

// File: rtl/conv_window_addr_gen.sv
// Walks one convolution pass: for each output window, emits image/weight address pairs
// for every filter tap across all channels, with valid/ready backpressure.
module conv_window_addr_gen #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8,
    parameter int CH_W   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [DIM_W-1:0]       cfg_img_rows,
    input  logic [DIM_W-1:0]       cfg_img_cols,
    input  logic [DIM_W-1:0]       cfg_flt_rows,
    input  logic [DIM_W-1:0]       cfg_flt_cols,
    input  logic [DIM_W-1:0]       cfg_stride,
    input  logic [CH_W-1:0]        cfg_channels,
    conv_window_addr_gen_if.master m,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e state_q, state_d;

    logic [DIM_W-1:0]  img_rows_q, img_rows_d, img_cols_q, img_cols_d;
    logic [DIM_W-1:0]  flt_rows_q, flt_rows_d, flt_cols_q, flt_cols_d;
    logic [DIM_W-1:0]  stride_q, stride_d;
    logic [CH_W-1:0]   chans_q, chans_d;

    logic [DIM_W-1:0]  fc_q, fc_d, fr_q, fr_d, c0_q, c0_d, r0_q, r0_d;
    logic [DIM_W-1:0]  out_row_q, out_row_d, out_col_q, out_col_d;
    logic [CH_W-1:0]   ch_q, ch_d;

    logic [ADDR_W-1:0] img_addr_q, img_addr_d, wgt_addr_q, wgt_addr_d;
    logic              dp_last_q, dp_last_d;
    logic              cfg_err_q, cfg_err_d;

    logic              cfg_bad, start_ok, hs, upd;
    logic              fc_wrap, fr_wrap, ch_wrap, c0_adv, r0_adv, last_tap;
    logic [DIM_W+1:0]  c0_reach, r0_reach;

    always_comb begin
        cfg_bad  = (cfg_img_rows == '0) || (cfg_img_cols == '0) ||
                   (cfg_flt_rows == '0) || (cfg_flt_cols == '0) ||
                   (cfg_stride == '0)   || (cfg_channels == '0) ||
                   (cfg_flt_rows > cfg_img_rows) || (cfg_flt_cols > cfg_img_cols);
        start_ok = (state_q == IDLE) && start && !cfg_bad;
        hs       = (state_q == RUN) && m.addr_ready;
        upd      = start_ok || hs;

        fc_wrap  = (fc_q == flt_cols_q - DIM_W'(1));
        fr_wrap  = (fr_q == flt_rows_q - DIM_W'(1));
        ch_wrap  = (ch_q == chans_q - CH_W'(1));
        // The next origin must leave room for a full filter window inside the image.
        c0_reach = {2'b00, c0_q} + {2'b00, stride_q} + {2'b00, flt_cols_q};
        r0_reach = {2'b00, r0_q} + {2'b00, stride_q} + {2'b00, flt_rows_q};
        c0_adv   = (c0_reach <= {2'b00, img_cols_q});
        r0_adv   = (r0_reach <= {2'b00, img_rows_q});
        last_tap = fc_wrap && fr_wrap && ch_wrap && !c0_adv && !r0_adv;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (hs && last_tap) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        m.addr_valid = (state_q == RUN);
        busy         = (state_q == RUN) || (state_q == DONE);
        done         = (state_q == DONE);
    end

    always_comb begin
        img_rows_d = img_rows_q;
        img_cols_d = img_cols_q;
        flt_rows_d = flt_rows_q;
        flt_cols_d = flt_cols_q;
        stride_d   = stride_q;
        chans_d    = chans_q;
        fc_d       = fc_q;
        fr_d       = fr_q;
        ch_d       = ch_q;
        c0_d       = c0_q;
        r0_d       = r0_q;
        out_row_d  = out_row_q;
        out_col_d  = out_col_q;
        cfg_err_d  = (state_q == IDLE) && start && cfg_bad;

        if (start_ok) begin
            img_rows_d = cfg_img_rows;
            img_cols_d = cfg_img_cols;
            flt_rows_d = cfg_flt_rows;
            flt_cols_d = cfg_flt_cols;
            stride_d   = cfg_stride;
            chans_d    = cfg_channels;
            fc_d       = '0;
            fr_d       = '0;
            ch_d       = '0;
            c0_d       = '0;
            r0_d       = '0;
            out_row_d  = '0;
            out_col_d  = '0;
        end else if (hs) begin
            fc_d = fc_wrap ? '0 : fc_q + DIM_W'(1);
            if (fc_wrap) begin
                fr_d = fr_wrap ? '0 : fr_q + DIM_W'(1);
                if (fr_wrap) begin
                    ch_d = ch_wrap ? '0 : ch_q + CH_W'(1);
                    if (ch_wrap) begin
                        if (c0_adv) begin
                            c0_d      = c0_q + stride_q;
                            out_col_d = out_col_q + DIM_W'(1);
                        end else begin
                            c0_d      = '0;
                            out_col_d = '0;
                            if (r0_adv) begin
                                r0_d      = r0_q + stride_q;
                                out_row_d = out_row_q + DIM_W'(1);
                            end else begin
                                r0_d      = '0;
                                out_row_d = '0;
                            end
                        end
                    end
                end
            end
        end
    end

    // Addresses are formed from the next counter values so they register alongside them.
    always_comb begin
        img_addr_d = ADDR_W'(ch_d) * ADDR_W'(img_rows_d) * ADDR_W'(img_cols_d)
                   + (ADDR_W'(r0_d) + ADDR_W'(fr_d)) * ADDR_W'(img_cols_d)
                   + (ADDR_W'(c0_d) + ADDR_W'(fc_d));
        wgt_addr_d = (ADDR_W'(ch_d) * ADDR_W'(flt_rows_d) + ADDR_W'(fr_d)) * ADDR_W'(flt_cols_d)
                   + ADDR_W'(fc_d);
        dp_last_d  = (fc_d == flt_cols_d - DIM_W'(1)) &&
                     (fr_d == flt_rows_d - DIM_W'(1)) &&
                     (ch_d == chans_d - CH_W'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            img_rows_q <= '0;
            img_cols_q <= '0;
            flt_rows_q <= '0;
            flt_cols_q <= '0;
            stride_q   <= '0;
            chans_q    <= '0;
            fc_q       <= '0;
            fr_q       <= '0;
            ch_q       <= '0;
            c0_q       <= '0;
            r0_q       <= '0;
            out_row_q  <= '0;
            out_col_q  <= '0;
            img_addr_q <= '0;
            wgt_addr_q <= '0;
            dp_last_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            img_rows_q <= img_rows_d;
            img_cols_q <= img_cols_d;
            flt_rows_q <= flt_rows_d;
            flt_cols_q <= flt_cols_d;
            stride_q   <= stride_d;
            chans_q    <= chans_d;
            fc_q       <= fc_d;
            fr_q       <= fr_d;
            ch_q       <= ch_d;
            c0_q       <= c0_d;
            r0_q       <= r0_d;
            out_row_q  <= out_row_d;
            out_col_q  <= out_col_d;
            cfg_err_q  <= cfg_err_d;
            if (upd) begin
                img_addr_q <= img_addr_d;
                wgt_addr_q <= wgt_addr_d;
                dp_last_q  <= dp_last_d;
            end
        end
    end

    always_comb begin
        m.img_addr = img_addr_q;
        m.wgt_addr = wgt_addr_q;
        m.dp_last  = dp_last_q;
        m.out_row  = out_row_q;
        m.out_col  = out_col_q;
        cfg_err    = cfg_err_q;
    end
endmodule
